if_fetch_queue: RTL

- Parametrised instruction-fetch stage: owns the PC, issues requests to a fixed-latency-1 instruction memory and buffers returned words in a small fetch queue.
- Presents the queued {pc, instr} pairs to decode through a valid/ready handshake.
- Supports a redirect from branch/jump resolution (MEM stage) that flushes buffered and in-flight fetches.
- Sits between the PC/imem and the IF/ID boundary; replaces the free-running single-register fetch.

---
 rtl/if_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/if_fetch_queue.sv | 105 ++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared fetch-stage constants and the {pc, instr} payload type.
package if_pkg;

    localparam int unsigned         IF_XLEN     = 32;
    localparam int unsigned         IF_PC_STEP  = 4;
    localparam logic [IF_XLEN-1:0]  IF_RESET_PC = 32'h0000_0000;

    // Canonical NOP (addi x0, x0, 0); decode substitutes it on bubbles.
    localparam logic [IF_XLEN-1:0]  IF_NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer holding fetched {pc, instr} entries; supports any depth >= 2.
module fetch_fifo #(
    parameter int unsigned  WIDTH = 64,
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Pointer increment with explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Next-state for pointers and occupancy; flush wins over push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_push  = push_i & ~flush_i & ~full_o;
        do_pop   = pop_i  & ~flush_i & ~empty_o;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Status and head read.
    always_comb begin
        full_o  = (count_q == CW'(DEPTH));
        empty_o = (count_q == '0);
        count_o = count_q;
        rdata_o = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC register, credit-based issue to a latency-1 imem,
// in-flight/discard tracking and a fetch queue presented to decode.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned      XLEN     = IF_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(IF_RESET_PC),
    parameter int unsigned      PC_STEP  = IF_PC_STEP,
    parameter int unsigned      FQ_DEPTH = 4,
    localparam int unsigned     CW       = $clog2(FQ_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [CW-1:0]   fq_count
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic            discard_q, discard_d;
    logic            pop, push;
    logic            fifo_full, fifo_empty;
    logic [CW:0]     occupancy;
    entry_t          wr_entry, rd_entry;

    // Issue rule, response acceptance and next-state for PC / in-flight tracking.
    always_comb begin
        pop        = out_valid & out_ready;
        occupancy  = (CW+1)'(fq_count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
        imem_req   = reset & ~redirect_valid & (occupancy < (CW+1)'(FQ_DEPTH));
        imem_addr  = fetch_pc_q;
        // A response only counts if we were expecting one and it was not cancelled.
        push       = imem_rvalid & inflight_q & ~discard_q & ~redirect_valid;
        wr_entry   = '{pc: req_pc_q, instr: imem_rdata};

        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = imem_req;
        discard_d  = redirect_valid & inflight_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (imem_req) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            req_pc_d   = fetch_pc_q;
        end
    end

    // Fetch PC, request PC and in-flight/discard registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fq_count)
    );

    // Head of queue towards decode.
    always_comb begin
        out_valid = ~fifo_empty;
        out_pc    = rd_entry.pc;
        out_instr = rd_entry.instr;
    end

    // The issue credit check must make an overflowing push impossible.
    assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full))
        else $error("if_fetch_queue: response pushed into a full fetch queue");

endmodule
